// File: rtl/mac_result_accumulator.sv
// Frame accumulator behind the MAC tree: sums ACC_LEN accepted results and
// presents each frame total on a registered valid/ready output.
module mac_result_accumulator #(
    parameter int unsigned IN_WIDTH  = 18,
    parameter int unsigned ACC_LEN   = 4,
    parameter int unsigned CNT_WIDTH = 2,
    parameter int unsigned OUT_WIDTH = 20,
    // Reset value of frame_count; nonzero only to reach the wrap point quickly
    parameter logic [15:0] FRAME_COUNT_RESET = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          frame_count
);

    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic [15:0]          frame_count_q, frame_count_d;

    logic                 last;
    logic                 accept;
    logic                 xfer;
    logic [OUT_WIDTH-1:0] sum;

    assign last   = (cnt_q == CNT_WIDTH'(ACC_LEN - 1));
    assign xfer   = out_valid_q && out_ready;
    // Stall only when the completing sample would overwrite an unconsumed total
    assign in_ready = !clear && !(last && out_valid_q && !out_ready);
    assign accept = in_valid && in_ready;
    assign sum    = acc_q + OUT_WIDTH'(in_data);

    always_comb begin
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        frame_count_d = frame_count_q;

        if (xfer) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (last) begin
                // A completing accept overrides a same-cycle transfer: no bubble
                out_data_d    = sum;
                out_valid_d   = 1'b1;
                acc_d         = '0;
                cnt_d         = '0;
                frame_count_d = frame_count_q + 16'd1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q         <= '0;
            cnt_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_count_q <= FRAME_COUNT_RESET;
        end else begin
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign frame_count = frame_count_q;

endmodule
